mstore_txn_gen: RTL and testbench
=================================

# mstore_txn_gen

Transaction generator for matrix sequential stores. It splits one store request (nibble start address plus nibble count) into AXI INCR write bursts, subject to a 4 KiB page limit and a maximum burst length. It issues one AW per burst and streams one `txn_ctrl_t` per W beat to the sequential store stage. It counts outstanding B responses and pulses `req_done_o` once the whole request has been acknowledged.

## Interface
- `AxiDataWidth`, 64: W bus width in bits. `busNibbles = AxiDataWidth/4`, `busNSize = $clog2(busNibbles)`.
- `AxiAddrWidth`, 64: byte address width. Nibble addresses use `AxiAddrWidth+1` bits.
- `LenWidth`, 32: width of the request nibble count.
- `MaxBeats`, 256: maximum beats per burst, range 1..256.
- `MaxOutstanding`, 8: maximum bursts awaiting B.
- `axi_aw_t`, `txn_ctrl_t`: type parameters.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i` / `req_ready_o`  in/out  1  request handshake.
- `req_addr_i`  in  AxiAddrWidth+1  nibble start address.
- `req_nbs_i`  in  LenWidth  nibble count, must be ≥1.
- `axi_aw_valid_o` / `axi_aw_ready_i`  out/in  1  AW handshake.
- `axi_aw_o`  out  axi_aw_t  addr, len, size, burst.
- `txn_ctrl_valid_o` / `txn_ctrl_ready_i`  out/in  1  per-beat control handshake.
- `txn_ctrl_o`  out  txn_ctrl_t  fields: addr, isHead, rmnBeat, lbN, isFinalTxn.
- `axi_b_valid_i`  in  1  B response valid.
- `axi_b_ready_o`  out  1  B response ready.
- `req_done_o`  out  1  one-cycle pulse when the request is complete.

## Operation
- FSM states: S_IDLE, S_AW, S_BEAT, S_WAIT_B.
- **S_IDLE**
  - `req_ready_o=1`.
  - On handshake, latch the cursor address `cur` and the remaining count `rmn`, then go to S_AW.
- **Burst calculation** (combinational from `cur`, `rmn`):
  - Bus offset: `off = cur[busNSize-1:0]`.
  - Nibbles to the page boundary: `pg = 8192 - cur[12:0]`.
  - Burst size: `txn = min(rmn, pg, MaxBeats*busNibbles - off)`.
  - Beat count: `beats = ceil((off+txn)/busNibbles)`.
  - Last-beat nibble end: `lbN = ((off+txn-1) mod busNibbles)+1`. Width is busNSize+1; value range 1..busNibbles.
  - Final burst flag: `isFinalTxn = (txn == rmn)`.
- **S_AW**
  - Assert `axi_aw_valid_o` only when `outstanding < MaxOutstanding`.
  - AW fields:
    - `addr = (cur>>1)` with the low log2(AxiDataWidth/8) bits cleared.
    - `len = beats-1`.
    - `size = log2(AxiDataWidth/8)`.
    - `burst = INCR`.
  - On handshake: `outstanding++`, load `rmnBeat = beats-1`, go to S_BEAT.
- **S_BEAT**
  - Assert `txn_ctrl_valid_o`.
  - `txn_ctrl_o` fields:
    - `addr = cur`.
    - `isHead` = 1 on the first beat of the burst only.
    - `rmnBeat` = current count.
    - `lbN`, `isFinalTxn` as computed for this burst.
  - Each handshake decrements `rmnBeat`.
  - Handshake with `rmnBeat==0` ends the burst:
    - `cur += txn`, `rmn -= txn`.
    - If `isFinalTxn`, go to S_WAIT_B; otherwise go to S_AW.
- **S_WAIT_B**
  - When `outstanding==0`, pulse `req_done_o` and return to S_IDLE.
- **B channel**
  - `axi_b_ready_o=1` whenever `outstanding>0`.
  - Each B handshake does `outstanding--`.
  - AW handshake and B handshake in the same cycle: counter unchanged.
  - B response codes are ignored.
- **Boundary conditions**
  - A burst ending exactly on the 4 KiB boundary produces no empty follow-on burst.
  - The `outstanding == MaxOutstanding` stall takes effect in S_AW only; beats already started keep streaming.
  - `req_nbs_i==0` is illegal (assertion).

## Timing
- Reset values: all valids and `req_done_o` = 0, `req_ready_o` = 0 during reset then 1, state S_IDLE, `outstanding` = 0.
- Request accept to AW valid: 1 cycle.
- AW handshake to first `txn_ctrl_valid_o`: 1 cycle.
- Back-to-back beats: one beat per cycle while `txn_ctrl_ready_i` is high.
- Last beat of a burst to next AW valid: 1 cycle.
- Last B handshake to `req_done_o`: 1 cycle.
- Valids never drop and payloads stay stable until the corresponding handshake.
- Reset mid-operation aborts immediately. Outstanding bursts are forgotten; the downstream stage is reset in the same domain.

## Structure
- The `txn_ctrl_t` fields and the 4 KiB constant (`PageNibbles=8192`) belong in `vlsu_pkg`, shared with the sequential store stage.
- `axi_aw_t` comes from the top-level AXI typedefs.
- Sub-module `mstore_burst_calc`: purely combinational `txn`/`beats`/`lbN`/`isFinalTxn` computation. It is kept separate so it can be unit-tested alone.

## Test plan
All cases use AxiDataWidth=64 (busNibbles=16) unless stated.
- **Aligned single beat:** addr 0x10, nbs 16 -> one AW (addr 0x8, len 0, size 3, INCR); one ctrl beat (isHead 1, rmnBeat 0, lbN 16, isFinalTxn 1).
- **Unaligned multi-beat:** addr 0x3, nbs 40 -> AW addr 0x0, len 2; ctrl beats with rmnBeat 2,1,0 and isHead 1,0,0; lbN 11; isFinalTxn 1.
- **4 KiB crossing:** addr 0x1FF0, nbs 32 -> AW 0xFF8 len 0 (isFinalTxn 0), then AW 0x1000 len 0 (lbN 16, isFinalTxn 1).
- **MaxBeats split:** addr 0, nbs 4112 -> AW len 255, then AW addr 0x800 len 0; 257 ctrl beats total.
- **Backpressure and B window:** MaxOutstanding=1, `txn_ctrl_ready_i` toggled, B withheld 10 cycles -> second AW valid only after the first B; payload stable while stalled; `req_done_o` 1 cycle after the last B.
- **Reset mid-burst:** `rst_ni` low during S_BEAT -> all valids 0 in the same cycle, outstanding 0; a subsequent request completes normally.

Source files
------------

// File: rtl/mstore_txn_gen_pkg.sv
// Shared types and constants for the matrix sequential-store transaction generator and store stage.
// Nibble addresses are one bit wider than AXI byte addresses.
package mstore_txn_gen_pkg;

  localparam int unsigned DefAddrWidth = 64;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefLenWidth  = 32;
  localparam int unsigned DefBusNSize  = $clog2(DefDataWidth / 4);
  localparam int unsigned PageNibbles  = 8192;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [DefAddrWidth:0]   addr;
    logic                    is_head;
    logic [7:0]              rmn_beat;
    logic [DefBusNSize:0]    lb_n;
    logic                    is_final_txn;
  } mstore_ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AW,
    S_BEAT,
    S_WAIT_B
  } state_e;

endpackage

// File: rtl/mstore_txn_gen_if.sv
// Request, AW, per-beat control and B handshakes of the transaction generator.
// master = generator side, slave = request source / AXI / store-stage side.
interface mstore_txn_gen_if #(
  parameter int unsigned AxiAddrWidth = mstore_txn_gen_pkg::DefAddrWidth,
  parameter int unsigned LenWidth     = mstore_txn_gen_pkg::DefLenWidth
);
  import mstore_txn_gen_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [AxiAddrWidth:0] req_addr;
  logic [LenWidth-1:0]   req_nbs;
  logic                  axi_aw_valid;
  logic                  axi_aw_ready;
  axi_aw_chan_t          axi_aw;
  logic                  txn_ctrl_valid;
  logic                  txn_ctrl_ready;
  mstore_ctrl_t          txn_ctrl;
  logic                  axi_b_valid;
  logic                  axi_b_ready;
  logic                  req_done;

  modport master (
    input  req_valid, req_addr, req_nbs, axi_aw_ready, txn_ctrl_ready, axi_b_valid,
    output req_ready, axi_aw_valid, axi_aw, txn_ctrl_valid, txn_ctrl, axi_b_ready, req_done
  );

  modport slave (
    output req_valid, req_addr, req_nbs, axi_aw_ready, txn_ctrl_ready, axi_b_valid,
    input  req_ready, axi_aw_valid, axi_aw, txn_ctrl_valid, txn_ctrl, axi_b_ready, req_done
  );

endinterface

// File: rtl/mstore_burst_calc.sv
// Burst sizing for the next store burst: clipped by remaining count, 4 KiB page and MaxBeats.
// Purely combinational, no handshake.
module mstore_burst_calc
  import mstore_txn_gen_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned LenWidth     = 32,
  parameter int unsigned MaxBeats     = 256
) (
  input  logic [12:0]                      cur_lo,
  input  logic [LenWidth-1:0]              rmn,
  output logic [LenWidth-1:0]              txn,
  output logic [8:0]                       beats,
  output logic [$clog2(AxiDataWidth/4):0]  lb_n,
  output logic                             is_final_txn
);
  localparam int unsigned BusNibbles = AxiDataWidth / 4;
  localparam int unsigned BusNSize   = $clog2(BusNibbles);

  logic [LenWidth-1:0] off;
  logic [LenWidth-1:0] pg;
  logic [LenWidth-1:0] cap;
  logic [LenWidth-1:0] end_n;
  logic [BusNSize-1:0] last_lo;

  always_comb begin
    off = LenWidth'(cur_lo[BusNSize-1:0]);
    pg  = LenWidth'(PageNibbles) - LenWidth'(cur_lo);
    cap = LenWidth'(MaxBeats * BusNibbles) - off;
    txn = rmn;
    if (pg < txn) txn = pg;
    if (cap < txn) txn = cap;
    end_n   = off + txn;
    // the last beat always holds at least one nibble, so lb_n spans 1..BusNibbles
    last_lo = BusNSize'(end_n - LenWidth'(1));
    beats   = 9'((end_n + LenWidth'(BusNibbles - 1)) >> BusNSize);
    lb_n    = {1'b0, last_lo} + (BusNSize + 1)'(1);
    is_final_txn = (txn == rmn);
  end

endmodule

// File: rtl/mstore_txn_gen.sv
// Splits a nibble store request into AXI INCR bursts, one AW per burst and one control word per W beat.
// AW and beats follow their triggering handshake by one cycle; AW stalls at MaxOutstanding unacknowledged bursts.
module mstore_txn_gen
  import mstore_txn_gen_pkg::*;
#(
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned MaxBeats       = 256,
  parameter int unsigned MaxOutstanding = 8,
  parameter type axi_aw_t   = axi_aw_chan_t,
  parameter type txn_ctrl_t = mstore_ctrl_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  mstore_txn_gen_if.master bus
);
  localparam int unsigned BusNSize = $clog2(AxiDataWidth / 4);
  localparam int unsigned ByteSize = $clog2(AxiDataWidth / 8);
  localparam int unsigned OutW     = $clog2(MaxOutstanding + 1);
  localparam int unsigned NibAw    = AxiAddrWidth + 1;
  localparam logic [AxiAddrWidth-1:0] AddrMask = {{(AxiAddrWidth-ByteSize){1'b1}}, {ByteSize{1'b0}}};

  state_e              state;
  logic [NibAw-1:0]    cur;
  logic [LenWidth-1:0] rmn;
  logic [LenWidth-1:0] txn;
  logic [8:0]          beats;
  logic [BusNSize:0]   lb_n;
  logic                is_final_txn;
  logic                is_head;
  logic [7:0]          rmn_beat;
  logic [OutW-1:0]     outstanding;
  logic [OutW-1:0]     out_nxt;
  logic                req_rdy_q, aw_vld_q, ctrl_vld_q, done_q;
  logic                aw_hs, beat_hs, b_hs;
  axi_aw_t             aw_d;
  txn_ctrl_t           ctrl_d;

  mstore_burst_calc #(
    .AxiDataWidth (AxiDataWidth),
    .LenWidth     (LenWidth),
    .MaxBeats     (MaxBeats)
  ) u_calc (
    .cur_lo       (cur[12:0]),
    .rmn          (rmn),
    .txn          (txn),
    .beats        (beats),
    .lb_n         (lb_n),
    .is_final_txn (is_final_txn)
  );

  assign aw_hs   = aw_vld_q & bus.axi_aw_ready;
  assign beat_hs = ctrl_vld_q & bus.txn_ctrl_ready;
  assign b_hs    = bus.axi_b_valid & bus.axi_b_ready;
  assign out_nxt = outstanding + OutW'(aw_hs) - OutW'(b_hs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cur         <= '0;
      rmn         <= '0;
      rmn_beat    <= '0;
      is_head     <= 1'b0;
      outstanding <= '0;
      req_rdy_q   <= 1'b0;
      aw_vld_q    <= 1'b0;
      ctrl_vld_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      done_q      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          req_rdy_q <= 1'b1;
          if (req_rdy_q && bus.req_valid) begin
            cur       <= bus.req_addr;
            rmn       <= bus.req_nbs;
            req_rdy_q <= 1'b0;
            aw_vld_q  <= (out_nxt < OutW'(MaxOutstanding));
            state     <= S_AW;
          end
        end
        S_AW: begin
          if (aw_hs) begin
            aw_vld_q   <= 1'b0;
            ctrl_vld_q <= 1'b1;
            is_head    <= 1'b1;
            rmn_beat   <= 8'(beats - 9'd1);
            state      <= S_BEAT;
          end else begin
            // B responses retiring here release a stalled AW on the next cycle
            aw_vld_q <= (out_nxt < OutW'(MaxOutstanding));
          end
        end
        S_BEAT: begin
          if (beat_hs) begin
            is_head  <= 1'b0;
            rmn_beat <= rmn_beat - 8'd1;
            if (rmn_beat == 8'd0) begin
              ctrl_vld_q <= 1'b0;
              cur        <= cur + NibAw'(txn);
              rmn        <= rmn - txn;
              if (is_final_txn) begin
                state <= S_WAIT_B;
              end else begin
                aw_vld_q <= (out_nxt < OutW'(MaxOutstanding));
                state    <= S_AW;
              end
            end
          end
        end
        S_WAIT_B: begin
          if (out_nxt == '0) begin
            done_q    <= 1'b1;
            req_rdy_q <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    aw_d       = '0;
    aw_d.addr  = cur[AxiAddrWidth:1] & AddrMask;
    aw_d.len   = 8'(beats - 9'd1);
    aw_d.size  = 3'(ByteSize);
    aw_d.burst = BURST_INCR;
    ctrl_d              = '0;
    ctrl_d.addr         = cur;
    ctrl_d.is_head      = is_head;
    ctrl_d.rmn_beat     = rmn_beat;
    ctrl_d.lb_n         = lb_n;
    ctrl_d.is_final_txn = is_final_txn;
  end

  assign bus.req_ready      = req_rdy_q;
  assign bus.axi_aw_valid   = aw_vld_q;
  assign bus.axi_aw         = aw_d;
  assign bus.txn_ctrl_valid = ctrl_vld_q;
  assign bus.txn_ctrl       = ctrl_d;
  assign bus.axi_b_ready    = (outstanding != '0);
  assign bus.req_done       = done_q;

  a_nbs_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.req_valid && req_rdy_q) |-> (bus.req_nbs != '0));

endmodule

// File: tb/tb_mstore_txn_gen.sv
// Directed bench for mstore_txn_gen with one outstanding burst allowed, so every follow-on AW waits for a B.
module tb_mstore_txn_gen;
  import mstore_txn_gen_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mstore_txn_gen_if bus ();

  mstore_txn_gen #(.MaxOutstanding(1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input string tag, input logic [64:0] addr, input logic [31:0] nbs);
    int t = 0;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk({tag, ".req_ready"}, bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_nbs   = nbs;
    @(negedge clk_i);
    bus.req_valid = 1'b0;
    chk({tag, ".aw_lat"}, bus.axi_aw_valid, 1'b1);
  endtask

  task automatic expect_aw(input string tag, input logic [63:0] addr, input logic [7:0] len);
    int t = 0;
    while (!bus.axi_aw_valid && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk({tag, ".aw_valid"}, bus.axi_aw_valid, 1'b1);
    chk({tag, ".aw_addr"}, bus.axi_aw.addr, addr);
    chk({tag, ".aw_len"}, bus.axi_aw.len, len);
    chk({tag, ".aw_size"}, bus.axi_aw.size, 3'd3);
    chk({tag, ".aw_burst"}, bus.axi_aw.burst, 2'b01);
    bus.axi_aw_ready = 1'b1;
    @(negedge clk_i);
    bus.axi_aw_ready = 1'b0;
    chk({tag, ".aw_drop"}, bus.axi_aw_valid, 1'b0);
    chk({tag, ".ctrl_lat"}, bus.txn_ctrl_valid, 1'b1);
  endtask

  task automatic expect_beats(input string tag, input int n, input logic [64:0] addr,
                              input logic [4:0] lbn, input logic fin, input logic toggle);
    int got = 0;
    logic rdy;
    logic stalled = 1'b0;
    mstore_ctrl_t saved = '0;
    rdy = !toggle;
    while (got < n) begin
      bus.txn_ctrl_ready = rdy;
      if (!bus.txn_ctrl_valid) begin
        chk({tag, ".beat_valid"}, bus.txn_ctrl_valid, 1'b1);
        break;
      end
      if (stalled) chk({tag, ".stable"}, bus.txn_ctrl, saved);
      if (rdy) begin
        chk({tag, ".is_head"}, bus.txn_ctrl.is_head, (got == 0));
        chk({tag, ".rmn_beat"}, bus.txn_ctrl.rmn_beat, n - 1 - got);
        if (got == 0 || got == n - 1) begin
          chk({tag, ".addr"}, bus.txn_ctrl.addr, addr);
          chk({tag, ".lb_n"}, bus.txn_ctrl.lb_n, lbn);
          chk({tag, ".final"}, bus.txn_ctrl.is_final_txn, fin);
        end
        got++;
        stalled = 1'b0;
      end else begin
        saved   = bus.txn_ctrl;
        stalled = 1'b1;
      end
      @(negedge clk_i);
      if (toggle) rdy = !rdy;
    end
    bus.txn_ctrl_ready = 1'b0;
    chk({tag, ".beat_count"}, got, n);
    chk({tag, ".ctrl_drop"}, bus.txn_ctrl_valid, 1'b0);
  endtask

  task automatic give_b(input string tag, input logic exp_done);
    int t = 0;
    while (!bus.axi_b_ready && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk({tag, ".b_ready"}, bus.axi_b_ready, 1'b1);
    bus.axi_b_valid = 1'b1;
    @(negedge clk_i);
    bus.axi_b_valid = 1'b0;
    chk({tag, ".done"}, bus.req_done, exp_done);
    if (exp_done) begin
      @(negedge clk_i);
      chk({tag, ".done_pulse"}, bus.req_done, 1'b0);
      chk({tag, ".idle_ready"}, bus.req_ready, 1'b1);
      chk({tag, ".b_idle"}, bus.axi_b_ready, 1'b0);
    end
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.req_nbs        = '0;
    bus.axi_aw_ready   = 1'b0;
    bus.txn_ctrl_ready = 1'b0;
    bus.axi_b_valid    = 1'b0;

    repeat (3) @(negedge clk_i);
    chk("rst.req_ready", bus.req_ready, 1'b0);
    chk("rst.aw_valid", bus.axi_aw_valid, 1'b0);
    chk("rst.ctrl_valid", bus.txn_ctrl_valid, 1'b0);
    chk("rst.b_ready", bus.axi_b_ready, 1'b0);
    chk("rst.done", bus.req_done, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst.ready_after", bus.req_ready, 1'b1);

    // aligned single beat
    send_req("aligned", 65'h10, 32'd16);
    expect_aw("aligned", 64'h8, 8'd0);
    expect_beats("aligned", 1, 65'h10, 5'd16, 1'b1, 1'b0);
    give_b("aligned", 1'b1);

    // unaligned start, three beats, partial last beat
    send_req("unal", 65'h3, 32'd40);
    expect_aw("unal", 64'h0, 8'd2);
    expect_beats("unal", 3, 65'h3, 5'd11, 1'b1, 1'b0);
    give_b("unal", 1'b1);

    // 4 KiB page crossing splits into two single-beat bursts
    send_req("page", 65'h1FF0, 32'd32);
    expect_aw("page1", 64'hFF8, 8'd0);
    expect_beats("page1", 1, 65'h1FF0, 5'd16, 1'b0, 1'b0);
    chk("page.aw_stall", bus.axi_aw_valid, 1'b0);
    give_b("page1", 1'b0);
    chk("page.aw_after_b", bus.axi_aw_valid, 1'b1);
    expect_aw("page2", 64'h1000, 8'd0);
    expect_beats("page2", 1, 65'h2000, 5'd16, 1'b1, 1'b0);
    give_b("page2", 1'b1);

    // MaxBeats split: 256 beats then one more
    send_req("split", 65'h0, 32'd4112);
    expect_aw("split1", 64'h0, 8'd255);
    expect_beats("split1", 256, 65'h0, 5'd16, 1'b0, 1'b0);
    give_b("split1", 1'b0);
    chk("split.aw_after_b", bus.axi_aw_valid, 1'b1);
    expect_aw("split2", 64'h800, 8'd0);
    expect_beats("split2", 1, 65'h1000, 5'd16, 1'b1, 1'b0);
    give_b("split2", 1'b1);

    // toggled beat ready, B withheld for 10 cycles
    send_req("bp", 65'h1FE0, 32'd48);
    expect_aw("bp1", 64'hFF0, 8'd1);
    expect_beats("bp1", 2, 65'h1FE0, 5'd16, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("bp.aw_held", bus.axi_aw_valid, 1'b0);
      @(negedge clk_i);
    end
    give_b("bp1", 1'b0);
    chk("bp.aw_after_b", bus.axi_aw_valid, 1'b1);
    expect_aw("bp2", 64'h1000, 8'd0);
    expect_beats("bp2", 1, 65'h2000, 5'd16, 1'b1, 1'b1);
    give_b("bp2", 1'b1);

    // reset in the middle of a 4-beat burst
    send_req("mid", 65'h0, 32'd64);
    expect_aw("mid", 64'h0, 8'd3);
    bus.txn_ctrl_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    bus.txn_ctrl_ready = 1'b0;
    chk("mid.streaming", bus.txn_ctrl_valid, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid.ctrl_valid", bus.txn_ctrl_valid, 1'b0);
    chk("mid.aw_valid", bus.axi_aw_valid, 1'b0);
    chk("mid.b_ready", bus.axi_b_ready, 1'b0);
    chk("mid.req_ready", bus.req_ready, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    send_req("post", 65'h25, 32'd5);
    expect_aw("post", 64'h10, 8'd0);
    expect_beats("post", 1, 65'h25, 5'd10, 1'b1, 1'b0);
    give_b("post", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
